uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of entries; power of two, 4..256.
REQ-002 SHALL have parameter ALMFULL_LVL, default DEPTH-2: level at or above which o_almfull asserts.
REQ-003 SHALL have i_clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have i_rx_done, input, 1: one-cycle write strobe from the receiver.
REQ-006 SHALL have i_rx_word, input, 8: received byte.
REQ-007 SHALL have i_rx_frame_error / i_rx_parity_error, input, 1 each: per-byte error flags, sampled with i_rx_done.
REQ-008 SHALL have o_rd_valid, output, 1: head entry available.
REQ-009 SHALL have i_rd_ready, input, 1: consumer pop request.
REQ-010 SHALL have o_rd_data, output, 8, plus o_rd_frame_error / o_rd_parity_error, output, 1: head entry fields.
REQ-011 SHALL have o_level, output, $clog2(DEPTH)+1: current occupancy.
REQ-012 SHALL have o_empty, o_full, o_almfull, output, 1 each; o_almfull drives the receiver's i_fifo_almfull.
REQ-013 SHALL have o_overflow, output, 1: sticky lost-byte flag; i_overflow_clr, input, 1: clears it.
REQ-014 SHALL have i_flush, input, 1: synchronous discard of all entries.
REQ-015 SHALL have i_timeout_cycles, input, 32: idle-timeout threshold, 0 disables; o_rx_timeout, output, 1.

Function
REQ-016 SHALL store {frame_error, parity_error, data} as one entry on every cycle i_rx_done=1 and not full (or full with pop same cycle).
REQ-017 SHALL present head entry first-word-fall-through: o_rd_valid = !o_empty; pop occurs when o_rd_valid && i_rd_ready.
REQ-018 SHALL make a write into an empty FIFO visible on o_rd_valid the cycle after i_rx_done (latency 1, no bypass).
REQ-019 SHALL, on simultaneous push and pop, keep o_level unchanged, including when full or when level=1.
REQ-020 SHALL, on push when full without pop, drop the byte, keep contents, set o_overflow next cycle.
REQ-021 SHALL hold o_overflow until i_overflow_clr; set has priority over clear in the same cycle.
REQ-022 SHALL ignore i_rd_ready when empty (no pointer change, no underflow).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from an extra pointer MSB or o_level.
REQ-024 SHALL assert o_full when o_level==DEPTH, o_empty when 0, o_almfull when o_level>=ALMFULL_LVL, all registered-consistent with o_level.
REQ-025 SHALL, on i_flush, set o_level to 0 next cycle, overriding any same-cycle push or pop; o_overflow unaffected.
REQ-026 SHALL run a 32-bit saturating idle counter: cleared on push, pop, flush, or empty; else incremented.
REQ-027 SHALL assert o_rx_timeout while !o_empty && i_timeout_cycles!=0 && counter>=i_timeout_cycles; deassert the cycle after clearing event.
REQ-028 SHALL hold o_rd_data and error outputs stable while o_rd_valid && !i_rd_ready.

Reset
REQ-029 SHALL on i_rst set pointers, o_level, idle counter to 0; o_empty=1; o_full, o_almfull, o_overflow, o_rx_timeout, o_rd_valid=0; o_rd_data and error outputs=0.
REQ-030 SHALL apply reset immediately (asynchronously) even mid-write or mid-read; storage array need not be reset.

Structure
REQ-031 SHALL place the entry struct type rx_fifo_entry_t (data, frame_error, parity_error) in uart_pkg.
REQ-032 SHALL implement storage in one sub-module uart_fifo_mem (parameterised width/depth register array, one write port, one async read port).
REQ-033 SHALL keep pointer, level, overflow and timeout control in uart_rx_fifo.

Verification
REQ-034 Reset, then push 0xA5,0x3C -> o_level=2, o_rd_data=0xA5 with both error outputs 0; pop once -> o_rd_data=0x3C, o_level=1.
REQ-035 DEPTH=16: push 16 bytes 0x00..0x0F -> o_almfull at level 14, o_full at 16; 17th push 0xFF -> dropped, o_overflow=1, pops return 0x00..0x0F in order.
REQ-036 Full FIFO, push 0x55 with pop same cycle -> o_level stays 16, 0x55 read last after wrap.
REQ-037 Push 0x81 with i_rx_parity_error=1 and 0x42 with i_rx_frame_error=1 -> flags reappear on matching entries only.
REQ-038 i_timeout_cycles=10, push one byte, idle -> o_rx_timeout asserts 10 cycles after push; pop -> deasserts next cycle; i_timeout_cycles=0 -> never asserts.
REQ-039 Level 5, assert i_flush with simultaneous push -> o_level=0, o_empty=1 next cycle; assert i_rst mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive FIFO: the stored entry layout and
// the width/saturation constants used by the idle-timeout logic.
package uart_pkg;

  // One received byte together with the error flags captured alongside it.
  typedef struct packed {
    logic       frame_error;
    logic       parity_error;
    logic [7:0] data;
  } rx_fifo_entry_t;

  localparam int unsigned ENTRY_W  = $bits(rx_fifo_entry_t);
  localparam logic [31:0] IDLE_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port
// and one asynchronous read port, so the head entry falls through as soon
// as the read pointer points at it.
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming entry into the slot addressed by the write pointer.
  // NOTE: the array has no reset; every slot is written before it can be
  // read, and the controller masks the read data while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and its consumer. Owns the
// pointers, occupancy flags, sticky overflow flag and idle-timeout counter;
// entry storage lives in uart_fifo_mem.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMFULL_LVL = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rx_done,
  input  logic [7:0]               i_rx_word,
  input  logic                     i_rx_frame_error,
  input  logic                     i_rx_parity_error,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [7:0]               o_rd_data,
  output logic                     o_rd_frame_error,
  output logic                     o_rd_parity_error,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almfull,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr,
  input  logic                     i_flush,
  input  logic [31:0]              i_timeout_cycles,
  output logic                     o_rx_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           empty_q, empty_d;
  logic           full_q, full_d;
  logic           almfull_q, almfull_d;
  logic           overflow_q, overflow_d;
  logic [31:0]    idle_q, idle_d;

  logic           push, pop, drop;
  rx_fifo_entry_t wr_entry, head_entry;

  assign wr_entry = '{frame_error:  i_rx_frame_error,
                      parity_error: i_rx_parity_error,
                      data:         i_rx_word};

  uart_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rd_ptr_q),
    .o_rdata (head_entry)
  );

  // Next-state for pointers, occupancy flags, overflow and idle counter.
  // NOTE: every variable gets a default at the top of the block so no
  // path through the if/else chain can leave it unassigned (no latches).
  always_comb begin
    pop        = !empty_q && i_rd_ready;
    push       = i_rx_done && (!full_q || pop);
    drop       = i_rx_done && full_q && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    idle_d     = idle_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end

    // A dropped byte wins over a same-cycle clear so the loss is never missed.
    if (drop)                overflow_d = 1'b1;
    else if (i_overflow_clr) overflow_d = 1'b0;

    if (push || pop || i_flush || empty_q) idle_d = '0;
    else if (idle_q != IDLE_MAX)           idle_d = idle_q + 32'd1;

    empty_d   = (level_d == '0);
    full_d    = (level_d == LW'(DEPTH));
    almfull_d = (level_d >= LW'(ALMFULL_LVL));
  end

  // State registers; the flags are registered from level_d so they always
  // agree with o_level in the same cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      almfull_q  <= 1'b0;
      overflow_q <= 1'b0;
      idle_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      almfull_q  <= almfull_d;
      overflow_q <= overflow_d;
      idle_q     <= idle_d;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign o_rd_valid        = !empty_q;
  assign o_rd_data         = empty_q ? 8'h00 : head_entry.data;
  assign o_rd_frame_error  = !empty_q && head_entry.frame_error;
  assign o_rd_parity_error = !empty_q && head_entry.parity_error;
  assign o_level           = level_q;
  assign o_empty           = empty_q;
  assign o_full            = full_q;
  assign o_almfull         = almfull_q;
  assign o_overflow        = overflow_q;
  assign o_rx_timeout      = !empty_q && (i_timeout_cycles != 32'd0) &&
                             (idle_q >= i_timeout_cycles);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model is
// stepped on every rising edge and compared against the DUT on every
// falling edge, with directed scenarios that also pin literal values.
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int ALMFULL = DEPTH - 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_done, i_rx_frame_error, i_rx_parity_error;
  logic [7:0]  i_rx_word;
  logic        o_rd_valid, i_rd_ready;
  logic [7:0]  o_rd_data;
  logic        o_rd_frame_error, o_rd_parity_error;
  logic [4:0]  o_level;
  logic        o_empty, o_full, o_almfull, o_overflow;
  logic        i_overflow_clr, i_flush;
  logic [31:0] i_timeout_cycles;
  logic        o_rx_timeout;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_rx_done         (i_rx_done),
    .i_rx_word         (i_rx_word),
    .i_rx_frame_error  (i_rx_frame_error),
    .i_rx_parity_error (i_rx_parity_error),
    .o_rd_valid        (o_rd_valid),
    .i_rd_ready        (i_rd_ready),
    .o_rd_data         (o_rd_data),
    .o_rd_frame_error  (o_rd_frame_error),
    .o_rd_parity_error (o_rd_parity_error),
    .o_level           (o_level),
    .o_empty           (o_empty),
    .o_full            (o_full),
    .o_almfull         (o_almfull),
    .o_overflow        (o_overflow),
    .i_overflow_clr    (i_overflow_clr),
    .i_flush           (i_flush),
    .i_timeout_cycles  (i_timeout_cycles),
    .o_rx_timeout      (o_rx_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: entry = {frame_error, parity_error, data}.
  logic [9:0] m_q[$];
  bit         m_ovf  = 0;
  longint     m_idle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Step the model with the inputs the DUT sees at this edge.
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_q.delete(); m_ovf = 0; m_idle = 0;
    end else begin
      bit was_empty, pop, push, drop;
      was_empty = (m_q.size() == 0);
      pop  = !was_empty && i_rd_ready;
      push = i_rx_done && (m_q.size() < DEPTH || pop);
      drop = i_rx_done && m_q.size() == DEPTH && !pop;
      if (i_flush) m_q.delete();
      else begin
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back({i_rx_frame_error, i_rx_parity_error, i_rx_word});
      end
      if (drop) m_ovf = 1;
      else if (i_overflow_clr) m_ovf = 0;
      if (push || pop || i_flush || was_empty) m_idle = 0;
      else if (m_idle < 64'hFFFF_FFFF) m_idle++;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      int n;
      logic [9:0] h;
      n = m_q.size();
      h = (n != 0) ? m_q[0] : 10'h000;
      check("level",     32'(o_level),     32'(n));
      check("empty",     32'(o_empty),     32'(n == 0));
      check("full",      32'(o_full),      32'(n == DEPTH));
      check("almfull",   32'(o_almfull),   32'(n >= ALMFULL));
      check("rd_valid",  32'(o_rd_valid),  32'(n != 0));
      check("rd_data",   32'(o_rd_data),   32'(h[7:0]));
      check("rd_pe",     32'(o_rd_parity_error), 32'(h[8]));
      check("rd_fe",     32'(o_rd_frame_error),  32'(h[9]));
      check("overflow",  32'(o_overflow),  32'(m_ovf));
      check("timeout",   32'(o_rx_timeout),
            32'(n != 0 && i_timeout_cycles != 0 && m_idle >= longint'(i_timeout_cycles)));
    end
  end

  // Apply one cycle of stimulus, return just after the following falling edge.
  task automatic cyc(input logic rx, input logic [7:0] w, input logic fe, input logic pe,
                     input logic rd, input logic fl, input logic clr);
    i_rx_done = rx; i_rx_word = w; i_rx_frame_error = fe; i_rx_parity_error = pe;
    i_rd_ready = rd; i_flush = fl; i_overflow_clr = clr;
    @(negedge i_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    cyc(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},    32'(o_level),           32'd0);
    check({tag, "_empty"},    32'(o_empty),           32'd1);
    check({tag, "_full"},     32'(o_full),            32'd0);
    check({tag, "_almfull"},  32'(o_almfull),         32'd0);
    check({tag, "_overflow"}, 32'(o_overflow),        32'd0);
    check({tag, "_timeout"},  32'(o_rx_timeout),      32'd0);
    check({tag, "_valid"},    32'(o_rd_valid),        32'd0);
    check({tag, "_data"},     32'(o_rd_data),         32'd0);
    check({tag, "_fe"},       32'(o_rd_frame_error),  32'd0);
    check({tag, "_pe"},       32'(o_rd_parity_error), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_rx_done = 0; i_rx_word = 0; i_rx_frame_error = 0; i_rx_parity_error = 0;
    i_rd_ready = 0; i_flush = 0; i_overflow_clr = 0; i_timeout_cycles = 0;
    #1;
    check_reset_values("por");
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    idle();

    // Two bytes in, head is the first; one pop exposes the second.
    push(8'hA5); push(8'h3C); idle();
    check("basic_level2", 32'(o_level),   32'd2);
    check("basic_head",   32'(o_rd_data), 32'hA5);
    check("basic_errs",   32'({o_rd_frame_error, o_rd_parity_error}), 32'd0);
    pop();
    check("basic_next",   32'(o_rd_data), 32'h3C);
    check("basic_level1", 32'(o_level),   32'd1);
    pop();

    // Fill to full, watch almfull/full thresholds, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      check("fill_almfull", 32'(o_almfull), 32'(i + 1 >= 14));
      check("fill_full",    32'(o_full),    32'(i + 1 == 16));
    end
    push(8'hFF);
    check("ovf_set",   32'(o_overflow), 32'd1);
    check("ovf_level", 32'(o_level),    32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(o_rd_data), 32'(i));
      pop();
    end
    check("drain_empty", 32'(o_empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(o_overflow), 32'd0);

    // Full FIFO with push and pop together keeps the level at 16.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_pp_level", 32'(o_level),    32'd16);
    check("full_pp_ovf",   32'(o_overflow), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      check("wrap_order", 32'(o_rd_data), 32'(8'h10 + i));
      pop();
    end
    check("wrap_last", 32'(o_rd_data), 32'h55);
    pop();

    // Error flags travel with their own entries.
    cyc(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err1_data", 32'(o_rd_data), 32'h81);
    check("err1_flags", 32'({o_rd_frame_error, o_rd_parity_error}), 32'b01);
    pop();
    check("err2_data", 32'(o_rd_data), 32'h42);
    check("err2_flags", 32'({o_rd_frame_error, o_rd_parity_error}), 32'b10);
    pop();

    // Idle timeout asserts ten cycles after the push, clears after a pop.
    i_timeout_cycles = 32'd10;
    push(8'h77);
    for (int n = 1; n <= 10; n++) begin
      idle();
      if (n == 9)  check("to_before", 32'(o_rx_timeout), 32'd0);
      if (n == 10) check("to_at10",   32'(o_rx_timeout), 32'd1);
    end
    pop();
    check("to_clear", 32'(o_rx_timeout), 32'd0);
    i_timeout_cycles = 32'd0;
    push(8'h78);
    for (int n = 0; n < 30; n++) idle();
    check("to_disabled", 32'(o_rx_timeout), 32'd0);
    pop();

    // Flush beats a same-cycle push.
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    check("fl_level5", 32'(o_level), 32'd5);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fl_level0", 32'(o_level), 32'd0);
    check("fl_empty",  32'(o_empty), 32'd1);

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) == 0) i_timeout_cycles = 32'($urandom_range(0, 3) * 6);
      cyc($urandom_range(0, 99) < 55, 8'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 99) < (c % 400 < 200 ? 35 : 70),
          $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset between edges while full and overflowed.
    i_timeout_cycles = 32'd3;
    for (int i = 0; i < DEPTH + 1; i++) push(8'(8'hC0 + i));
    check("pre_rst_ovf", 32'(o_overflow), 32'd1);
    i_rx_done = 1'b1; i_rd_ready = 1'b1;
    #2 i_rst = 1'b1;
    #1;
    check_reset_values("async");
    i_rx_done = 1'b0; i_rd_ready = 1'b0;
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    for (int n = 0; n < 4; n++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
